// File: rtl/load_unit.sv
// Load unit: accepts one load request at a time, issues a word-aligned
// memory read, extracts and extends the addressed byte/halfword/word, and
// writes it back to the register file. Misaligned or illegal loads produce
// a one-cycle load_err pulse instead of a memory access.
module load_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [4:0]      req_rd_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rsp_data_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            load_err_o,
    output logic            busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB,
        S_ERR
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]      lane_q, lane_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;

    logic            handshake;
    logic            illegal;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] extracted;

    assign handshake = req_valid_i && req_ready_o;

    // Classify the incoming request: unsupported funct3 or misalignment.
    always_comb begin
        illegal = 1'b0;
        unique case (req_funct3_i)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = req_addr_i[0];
            3'b010:         illegal = (req_addr_i[1:0] != 2'b00);
            default:        illegal = 1'b1;
        endcase
    end

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        byte_sel  = '0;
        extracted = mem_rsp_data_i;
        unique case (lane_q)
            2'd0:    byte_sel = mem_rsp_data_i[7:0];
            2'd1:    byte_sel = mem_rsp_data_i[15:8];
            2'd2:    byte_sel = mem_rsp_data_i[23:16];
            default: byte_sel = mem_rsp_data_i[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rsp_data_i[31:16] : mem_rsp_data_i[15:0];
        case (funct3_q)
            3'b000:  extracted = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  extracted = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b100:  extracted = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  extracted = {{(XLEN-16){1'b0}}, half_sel};
            default: extracted = mem_rsp_data_i;
        endcase
    end

    // Next-state and datapath capture logic.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        lane_d     = lane_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        data_d     = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    lane_d     = req_addr_i[1:0];
                    funct3_d   = req_funct3_i;
                    rd_d       = req_rd_i;
                    mem_addr_d = {req_addr_i[XLEN-1:2], 2'b00};
                    state_d    = illegal ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid_i) begin
                    data_d  = extracted;
                    state_d = S_WB;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and capture registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            lane_q     <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            lane_q     <= lane_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
        end
    end

    // Outputs decode from state only; write port is zeroed when idle.
    always_comb begin
        req_ready_o     = (state_q == S_IDLE);
        busy_o          = (state_q != S_IDLE);
        mem_req_valid_o = (state_q == S_REQ);
        mem_addr_o      = mem_addr_q;
        load_err_o      = (state_q == S_ERR);
        rf_we_o         = (state_q == S_WB) && (rd_q != 5'd0);
        rf_waddr_o      = rf_we_o ? rd_q : '0;
        rf_wdata_o      = rf_we_o ? data_q : '0;
    end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: stimulus pushes expected write-backs and
// error pulses; a negedge monitor pops and compares them as they appear.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic [2:0]  req_funct3_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_data_i = '0;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        load_err_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t  wb_q[$];
    int   err_q[$];

    load_unit #(.XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_funct3_i    (req_funct3_i),
        .req_rd_i        (req_rd_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_addr_o      (mem_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .rf_we_o         (rf_we_o),
        .rf_waddr_o      (rf_waddr_o),
        .rf_wdata_o      (rf_wdata_o),
        .load_err_o      (load_err_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes back or errors.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we_o) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_rf_we", 32'd1, 32'd0);
                end else begin
                    wb_t e;
                    e = wb_q.pop_front();
                    check("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, e.rd});
                    check("rf_wdata", rf_wdata_o, e.data);
                end
            end else begin
                check("idle_wport", {27'd0, rf_waddr_o} | rf_wdata_o, 32'd0);
            end
            if (load_err_o) begin
                if (err_q.size() == 0) check("unexpected_load_err", 32'd1, 32'd0);
                else void'(err_q.pop_front());
            end
        end
    end

    // One load; stall = cycles mem_req_ready held low; early = inject a
    // response pulse while in REQ that must be ignored.
    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] data, input int stall, input logic early,
                           input logic is_err, input logic [31:0] exp_val);
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
        req_valid_i  = 1'b1;
        req_addr_i   = addr;
        req_funct3_i = f3;
        req_rd_i     = rd;
        if (is_err) err_q.push_back(1);
        else if (rd != 5'd0) wb_q.push_back('{rd: rd, data: exp_val});
        @(negedge clk);
        req_valid_i = 1'b0;
        if (is_err) begin
            check("err_pulse", {31'd0, load_err_o}, 32'd1);
            check("err_no_memreq", {31'd0, mem_req_valid_o}, 32'd0);
            check("err_no_rfwe", {31'd0, rf_we_o}, 32'd0);
            @(negedge clk);
            check("err_ready_t2", {31'd0, req_ready_o}, 32'd1);
            check("err_pulse_end", {31'd0, load_err_o}, 32'd0);
            return;
        end
        check("memreq_t1", {31'd0, mem_req_valid_o}, 32'd1);
        check("mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        mem_req_ready_i = (stall == 0);
        mem_rsp_valid_i = early;
        mem_rsp_data_i  = 32'hBAD0_BAD0;
        for (int k = 1; k <= stall; k++) begin
            @(negedge clk);
            check("memreq_hold", {31'd0, mem_req_valid_o}, 32'd1);
            check("mem_addr_stable", mem_addr_o, addr & 32'hFFFF_FFFC);
            if (k == stall) mem_req_ready_i = 1'b1;
        end
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        check("wait_no_memreq", {31'd0, mem_req_valid_o}, 32'd0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = data;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        check("wb_busy", {31'd0, busy_o}, 32'd1);
        check("wb_rfwe", {31'd0, rf_we_o}, {31'd0, rd != 5'd0});
        @(negedge clk);
        check("ready_t4", {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_rfwe", {31'd0, rf_we_o}, 32'd0);
        check("rst_memreq", {31'd0, mem_req_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_err", {31'd0, load_err_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wport", {27'd0, rf_waddr_o} | rf_wdata_o, 32'd0);
        rst_n = 1'b1;

        // LB / LHU / LH / LBU / LW, hand-computed results.
        do_load(32'h0000_1003, 3'b000, 5'd5,  32'h80FF_FF00, 0, 1'b0, 1'b0, 32'hFFFF_FF80);
        do_load(32'h0000_2002, 3'b101, 5'd6,  32'hBEEF_1234, 0, 1'b0, 1'b0, 32'h0000_BEEF);
        do_load(32'h0000_2002, 3'b001, 5'd7,  32'hBEEF_1234, 0, 1'b0, 1'b0, 32'hFFFF_BEEF);
        do_load(32'h0000_0101, 3'b100, 5'd8,  32'h1234_5678, 0, 1'b0, 1'b0, 32'h0000_0056);
        do_load(32'h0000_0040, 3'b010, 5'd31, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        do_load(32'h0000_0000, 3'b001, 5'd9,  32'h0000_7FFF, 0, 1'b0, 1'b0, 32'h0000_7FFF);
        // Errors: misaligned LW, funct3=011, misaligned LHU, funct3=111.
        do_load(32'h0000_3001, 3'b010, 5'd3,  32'h0, 0, 1'b0, 1'b1, 32'h0);
        do_load(32'h0000_3000, 3'b011, 5'd3,  32'h0, 0, 1'b0, 1'b1, 32'h0);
        do_load(32'h0000_3003, 3'b101, 5'd3,  32'h0, 0, 1'b0, 1'b1, 32'h0);
        do_load(32'h0000_3000, 3'b111, 5'd3,  32'h0, 0, 1'b0, 1'b1, 32'h0);
        // LW rd=0 with 3 stall cycles and an early response pulse in REQ.
        do_load(32'h0000_4444, 3'b010, 5'd0,  32'h1111_2222, 3, 1'b1, 1'b0, 32'h0);

        // Response in IDLE must be ignored.
        @(negedge clk);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        check("idle_rsp_busy", {31'd0, busy_o}, 32'd0);
        check("idle_rsp_ready", {31'd0, req_ready_o}, 32'd1);
        mem_rsp_valid_i = 1'b0;

        // Reset during WAIT, then a stale response after release.
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_addr_i   = 32'h0000_5000;
        req_funct3_i = 3'b010;
        req_rd_i     = 5'd12;
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("in_rst_busy", {31'd0, busy_o}, 32'd0);
        check("in_rst_memreq", {31'd0, mem_req_valid_o}, 32'd0);
        check("in_rst_addr", mem_addr_o, 32'd0);
        rst_n = 1'b1;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        check("post_rst_busy", {31'd0, busy_o}, 32'd0);
        check("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
        @(negedge clk);
        check("post_rst_busy2", {31'd0, busy_o}, 32'd0);

        // A normal load still works after the abandoned one.
        do_load(32'h0000_6001, 3'b000, 5'd13, 32'h0000_7F00, 0, 1'b0, 1'b0, 32'h0000_007F);

        repeat (3) @(negedge clk);
        check("wb_queue_empty", wb_q.size(), 32'd0);
        check("err_queue_empty", err_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
